// File: rtl/decode_rf.sv
// decode_rf: RV32I decode stage with an integrated register file.
//
// Purpose:
//   Captures the fetched instruction into the IF/ID pipeline register, splits
//   it into fields, builds the sign-extended immediate, reads the two source
//   operands (with optional same-cycle write-back forwarding) and flags
//   encodings this core does not support.
//
// Parameters:
//   XLEN   - operand/register width (32 or 64); immediates sign-extend to XLEN
//   NREG   - architectural register count (16 or 32); x0 is hard-wired zero
//   BYPASS - 1: a committing write-back is visible on the read ports in the
//            same cycle; 0: reads return the pre-write value
//
// Ports:
//   CLK, RST                 clock (rising edge), async active-low reset
//   STALL, FLUSH             hold / invalidate the pipeline register
//   I_PC, I_INST, I_VALID    fetch slot
//   W_VALID, W_REG_D,
//   W_REG_D_V                write-back commit
//   D_PC, D_INST, D_VALID    latched fetch slot
//   D_OPCODE, D_FUNCT3,
//   D_FUNCT7, D_IMM          decoded fields and immediate
//   D_REG_D, D_REG_S1,
//   D_REG_S2                 register indices (rd forced to 0 for S/B)
//   D_REG_S1_V, D_REG_S2_V   operand values
//   D_ILLEGAL                valid slot with unknown opcode or bad index
//   DBG_ADDR, DBG_DATA       debug read port (architectural, no forwarding)
//
// Slot handshake: the fetch slot is accepted on every rising edge where
// STALL is low; an I_* value presented while STALL is high is not captured
// and fetch must hold it. FLUSH overrides STALL and empties the slot. The
// write-back port has no back-pressure: each edge with W_VALID high commits.
module decode_rf #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALL,
  input  logic            FLUSH,
  input  logic [31:0]     I_PC,
  input  logic [31:0]     I_INST,
  input  logic            I_VALID,
  input  logic            W_VALID,
  input  logic [4:0]      W_REG_D,
  input  logic [XLEN-1:0] W_REG_D_V,
  output logic [31:0]     D_PC,
  output logic [31:0]     D_INST,
  output logic            D_VALID,
  output logic [6:0]      D_OPCODE,
  output logic [2:0]      D_FUNCT3,
  output logic [6:0]      D_FUNCT7,
  output logic [XLEN-1:0] D_IMM,
  output logic [4:0]      D_REG_D,
  output logic [4:0]      D_REG_S1,
  output logic [4:0]      D_REG_S2,
  output logic [XLEN-1:0] D_REG_S1_V,
  output logic [XLEN-1:0] D_REG_S2_V,
  output logic            D_ILLEGAL,
  input  logic [4:0]      DBG_ADDR,
  output logic [XLEN-1:0] DBG_DATA
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // ---------------------------------------------------------------------------
  // IF/ID pipeline register
  // ---------------------------------------------------------------------------
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_valid;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pc    <= '0;
      r_inst  <= '0;
      r_valid <= 1'b0;
    end else if (FLUSH) begin
      r_pc    <= '0;
      r_inst  <= '0;
      r_valid <= 1'b0;
    end else if (!STALL) begin
      r_pc    <= I_PC;
      r_inst  <= I_INST;
      r_valid <= I_VALID;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: only x1..x(NREG-1) exist. Writes to x0 or beyond NREG
  // match no entry and are dropped. Independent of STALL/FLUSH.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] r_rf [1:NREG-1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 1; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (W_VALID && (W_REG_D == 5'(i))) r_rf[i] <= W_REG_D_V;
      end
    end
  end

  // Index names a physical register (not x0, below NREG).
  function automatic logic idx_live(input logic [4:0] idx);
    return (idx != 5'd0) && (32'(idx) < NREG);
  endfunction

  function automatic logic idx_over(input logic [4:0] idx);
    return 32'(idx) >= NREG;
  endfunction

  // ---------------------------------------------------------------------------
  // Field extraction and immediate generation
  // ---------------------------------------------------------------------------
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_imm32;
  logic        w_known;
  logic        w_use_rd;
  logic        w_use_rs1;
  logic        w_use_rs2;

  assign w_opcode = r_inst[6:0];
  assign w_rd     = r_inst[11:7];
  assign w_rs1    = r_inst[19:15];
  assign w_rs2    = r_inst[24:20];

  always_comb begin
    w_imm32   = '0;
    w_known   = 1'b1;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    unique case (w_opcode)
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: begin
        w_imm32   = {{20{r_inst[31]}}, r_inst[31:20]};
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
      end
      OP_STORE: begin
        w_imm32   = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        w_imm32   = {{19{r_inst[31]}}, r_inst[31], r_inst[7], r_inst[30:25],
                     r_inst[11:8], 1'b0};
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OP_JAL: begin
        w_imm32   = {{11{r_inst[31]}}, r_inst[31], r_inst[19:12], r_inst[20],
                     r_inst[30:21], 1'b0};
        w_use_rd  = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_imm32   = {r_inst[31:12], 12'b0};
        w_use_rd  = 1'b1;
      end
      OP_REG: begin
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      default: w_known = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand read with optional forwarding of the committing write-back
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] w_rs1_arch;
  logic [XLEN-1:0] w_rs2_arch;
  logic            w_fwd1;
  logic            w_fwd2;

  assign w_rs1_arch = idx_live(w_rs1) ? r_rf[w_rs1] : '0;
  assign w_rs2_arch = idx_live(w_rs2) ? r_rf[w_rs2] : '0;
  assign w_fwd1     = (BYPASS != 0) && W_VALID && (W_REG_D == w_rs1) && idx_live(w_rs1);
  assign w_fwd2     = (BYPASS != 0) && W_VALID && (W_REG_D == w_rs2) && idx_live(w_rs2);

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign D_PC       = r_pc;
  assign D_INST     = r_inst;
  assign D_VALID    = r_valid;
  assign D_OPCODE   = w_opcode;
  assign D_FUNCT3   = r_inst[14:12];
  assign D_FUNCT7   = r_inst[31:25];
  assign D_IMM      = XLEN'($signed(w_imm32));
  // S and B formats reuse inst[11:7] as immediate bits, so rd is reported as 0.
  assign D_REG_D    = ((w_opcode == OP_STORE) || (w_opcode == OP_BRANCH)) ? 5'd0 : w_rd;
  assign D_REG_S1   = w_rs1;
  assign D_REG_S2   = w_rs2;
  assign D_REG_S1_V = w_fwd1 ? W_REG_D_V : w_rs1_arch;
  assign D_REG_S2_V = w_fwd2 ? W_REG_D_V : w_rs2_arch;
  assign D_ILLEGAL  = r_valid & (~w_known
                               | (w_use_rd  & idx_over(w_rd))
                               | (w_use_rs1 & idx_over(w_rs1))
                               | (w_use_rs2 & idx_over(w_rs2)));
  assign DBG_DATA   = idx_live(DBG_ADDR) ? r_rf[DBG_ADDR] : '0;

endmodule

// File: tb/tb_decode_rf.sv
// tb_decode_rf: bench for decode_rf. Two instances share all inputs:
//   index 0: XLEN=32, NREG=32, BYPASS=1
//   index 1: XLEN=32, NREG=16, BYPASS=0
// A reference model (register arrays plus the pipeline slot) predicts every
// output each cycle; directed tables and sequences pin the key corner values.
module tb_decode_rf;

  logic        CLK;
  logic        RST;
  logic        STALL;
  logic        FLUSH;
  logic [31:0] I_PC;
  logic [31:0] I_INST;
  logic        I_VALID;
  logic        W_VALID;
  logic [4:0]  W_REG_D;
  logic [31:0] W_REG_D_V;
  logic [4:0]  DBG_ADDR;

  logic [31:0] a_pc    [2];
  logic [31:0] a_inst  [2];
  logic        a_valid [2];
  logic [6:0]  a_opc   [2];
  logic [2:0]  a_f3    [2];
  logic [6:0]  a_f7    [2];
  logic [31:0] a_imm   [2];
  logic [4:0]  a_rd    [2];
  logic [4:0]  a_rs1   [2];
  logic [4:0]  a_rs2   [2];
  logic [31:0] a_s1v   [2];
  logic [31:0] a_s2v   [2];
  logic        a_ill   [2];
  logic [31:0] a_dbg   [2];

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------------- clock/reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------- DUTs
  decode_rf #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .I_PC(I_PC), .I_INST(I_INST), .I_VALID(I_VALID),
    .W_VALID(W_VALID), .W_REG_D(W_REG_D), .W_REG_D_V(W_REG_D_V),
    .D_PC(a_pc[0]), .D_INST(a_inst[0]), .D_VALID(a_valid[0]),
    .D_OPCODE(a_opc[0]), .D_FUNCT3(a_f3[0]), .D_FUNCT7(a_f7[0]),
    .D_IMM(a_imm[0]), .D_REG_D(a_rd[0]), .D_REG_S1(a_rs1[0]), .D_REG_S2(a_rs2[0]),
    .D_REG_S1_V(a_s1v[0]), .D_REG_S2_V(a_s2v[0]), .D_ILLEGAL(a_ill[0]),
    .DBG_ADDR(DBG_ADDR), .DBG_DATA(a_dbg[0])
  );

  decode_rf #(.XLEN(32), .NREG(16), .BYPASS(0)) dut_e (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .I_PC(I_PC), .I_INST(I_INST), .I_VALID(I_VALID),
    .W_VALID(W_VALID), .W_REG_D(W_REG_D), .W_REG_D_V(W_REG_D_V),
    .D_PC(a_pc[1]), .D_INST(a_inst[1]), .D_VALID(a_valid[1]),
    .D_OPCODE(a_opc[1]), .D_FUNCT3(a_f3[1]), .D_FUNCT7(a_f7[1]),
    .D_IMM(a_imm[1]), .D_REG_D(a_rd[1]), .D_REG_S1(a_rs1[1]), .D_REG_S2(a_rs2[1]),
    .D_REG_S1_V(a_s1v[1]), .D_REG_S2_V(a_s2v[1]), .D_ILLEGAL(a_ill[1]),
    .DBG_ADDR(DBG_ADDR), .DBG_DATA(a_dbg[1])
  );

  // ---------------------------------------------------------------- model
  logic [31:0] m_rf [2][32];
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_valid;

  function automatic int nreg_of(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic bit byp_of(input int k);
    return k == 0;
  endfunction

  // Format letter from the opcode table: R I S B U J, '?' for unknown.
  function automatic byte fmt_of(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011:                                         return "R";
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111,
      7'b1110011:                                         return "I";
      7'b0100011:                                         return "S";
      7'b1100011:                                         return "B";
      7'b0110111, 7'b0010111:                             return "U";
      7'b1101111:                                         return "J";
      default:                                            return "?";
    endcase
  endfunction

  // Immediate by plain arithmetic: top bit supplies the sign weight.
  function automatic logic [31:0] imm_of(input logic [31:0] ins);
    int sgn;
    sgn = ins[31] ? -1 : 0;
    case (fmt_of(ins))
      "I": return 32'(sgn * 2048 + int'(ins[30:20]));
      "S": return 32'(sgn * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:7]));
      "B": return 32'(sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                      + int'(ins[11:8]) * 2);
      "J": return 32'(sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                      + int'(ins[30:21]) * 2);
      "U": return ins & 32'hFFFF_F000;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] read_of(input int k, input logic [4:0] r);
    if (r == 0 || int'(r) >= nreg_of(k)) return 32'd0;
    if (byp_of(k) && W_VALID && W_REG_D == r) return W_REG_D_V;
    return m_rf[k][r];
  endfunction

  function automatic bit illegal_of(input int k, input logic [31:0] ins, input bit v);
    byte f;
    bit  bad;
    int  n;
    f = fmt_of(ins);
    n = nreg_of(k);
    bad = (f == "?");
    if ((f == "R" || f == "I" || f == "U" || f == "J") && int'(ins[11:7]) >= n)  bad = 1;
    if ((f == "R" || f == "I" || f == "S" || f == "B") && int'(ins[19:15]) >= n) bad = 1;
    if ((f == "R" || f == "S" || f == "B") && int'(ins[24:20]) >= n)             bad = 1;
    return v && bad;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) m_rf[k][r] = 32'd0;
    m_pc = 0; m_inst = 0; m_valid = 0;
  endtask

  task automatic model_edge();
    if (!RST) return;
    for (int k = 0; k < 2; k++)
      if (W_VALID && W_REG_D != 0 && int'(W_REG_D) < nreg_of(k)) m_rf[k][W_REG_D] = W_REG_D_V;
    if (FLUSH) begin
      m_pc = 0; m_inst = 0; m_valid = 0;
    end else if (!STALL) begin
      m_pc = I_PC; m_inst = I_INST; m_valid = I_VALID;
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got 0x%08h expected 0x%08h", name, k, $time, act, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] ins;
    logic [4:0]  rd;
    byte         f;
    for (int k = 0; k < 2; k++) begin
      ins = m_inst;
      f   = fmt_of(ins);
      rd  = (f == "S" || f == "B") ? 5'd0 : ins[11:7];
      chk("pc",     k, a_pc[k],           m_pc);
      chk("inst",   k, a_inst[k],         m_inst);
      chk("valid",  k, 32'(a_valid[k]),   32'(m_valid));
      chk("opcode", k, 32'(a_opc[k]),     32'(ins[6:0]));
      chk("funct3", k, 32'(a_f3[k]),      32'(ins[14:12]));
      chk("funct7", k, 32'(a_f7[k]),      32'(ins[31:25]));
      chk("imm",    k, a_imm[k],          imm_of(ins));
      chk("rd",     k, 32'(a_rd[k]),      32'(rd));
      chk("rs1",    k, 32'(a_rs1[k]),     32'(ins[19:15]));
      chk("rs2",    k, 32'(a_rs2[k]),     32'(ins[24:20]));
      chk("rs1_v",  k, a_s1v[k],          read_of(k, ins[19:15]));
      chk("rs2_v",  k, a_s2v[k],          read_of(k, ins[24:20]));
      chk("illegal",k, 32'(a_ill[k]),     32'(illegal_of(k, ins, m_valid)));
      chk("dbg",    k, a_dbg[k],
          (DBG_ADDR == 0 || int'(DBG_ADDR) >= nreg_of(k)) ? 32'd0 : m_rf[k][DBG_ADDR]);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Inputs are set at posedge+1; outputs checked at posedge+3; model steps
  // on the edge with the same inputs the DUT saw.
  task automatic cycle();
    #2;
    check_all();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    STALL = 0; FLUSH = 0; I_PC = 0; I_INST = 0; I_VALID = 0;
    W_VALID = 0; W_REG_D = 0; W_REG_D_V = 0; DBG_ADDR = 0;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill0;
    logic        ill1;
  } vec_t;

  vec_t vecs[10];

  logic [6:0] ops[11];

  initial begin
    vecs[0] = '{32'h100, 32'h00500093, 5'd1,  32'h0000_0005, 1'b0, 1'b0}; // addi x1,x0,5
    vecs[1] = '{32'h104, 32'hFFF00093, 5'd1,  32'hFFFF_FFFF, 1'b0, 1'b0}; // addi x1,x0,-1
    vecs[2] = '{32'h108, 32'hFE000EE3, 5'd0,  32'hFFFF_FFFC, 1'b0, 1'b0}; // beq -4
    vecs[3] = '{32'h10C, 32'h00100A13, 5'd20, 32'h0000_0001, 1'b0, 1'b1}; // addi x20,x0,1
    vecs[4] = '{32'h110, 32'h0000007F, 5'd0,  32'h0000_0000, 1'b1, 1'b1}; // opcode 7F
    vecs[5] = '{32'h114, 32'h123452B7, 5'd5,  32'h1234_5000, 1'b0, 1'b0}; // lui x5
    vecs[6] = '{32'h118, 32'hFE512E23, 5'd0,  32'hFFFF_FFFC, 1'b0, 1'b0}; // sw x5,-4(x2)
    vecs[7] = '{32'h11C, 32'h0010006F, 5'd0,  32'h0000_0800, 1'b0, 1'b0}; // jal x0,+2048
    vecs[8] = '{32'h120, 32'h01F00033, 5'd0,  32'h0000_0000, 1'b0, 1'b1}; // add x0,x0,x31
    vecs[9] = '{32'h124, 32'h800002B7, 5'd5,  32'h8000_0000, 1'b0, 1'b0}; // lui x5,0x80000
    ops = '{7'b0110011, 7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011,
            7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};

    // ---- power-on reset
    idle_inputs();
    RST = 0;
    model_reset();
    cycle();
    cycle();
    RST = 1;
    cycle();

    // ---- write x5=0x11 while loading a slot, then reset mid-run with a
    //      pending write and load; both must be discarded
    W_VALID = 1; W_REG_D = 5; W_REG_D_V = 32'h11;
    I_PC = 32'h40; I_INST = 32'h00500093; I_VALID = 1; DBG_ADDR = 5;
    cycle();
    W_REG_D = 9; W_REG_D_V = 32'h77; DBG_ADDR = 9;
    RST = 0;
    model_reset();
    cycle();
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, 32'(a_valid[k]), 32'd0);
      chk("rst_dbg9",  k, a_dbg[k], 32'd0);
    end
    idle_inputs();
    RST = 1;
    cycle();

    // ---- table-driven decode vectors
    for (int i = 0; i < 10; i++) begin
      I_PC = vecs[i].pc; I_INST = vecs[i].inst; I_VALID = 1;
      cycle();
      for (int k = 0; k < 2; k++) begin
        chk("t_valid", k, 32'(a_valid[k]), 32'd1);
        chk("t_pc",    k, a_pc[k],         vecs[i].pc);
        chk("t_rd",    k, 32'(a_rd[k]),    32'(vecs[i].rd));
        chk("t_imm",   k, a_imm[k],        vecs[i].imm);
        chk("t_ill",   k, 32'(a_ill[k]),   32'((k == 0) ? vecs[i].ill0 : vecs[i].ill1));
      end
    end

    // ---- write/bypass: x5=0x11 then decode add x6,x5,x5 under a new write
    W_VALID = 1; W_REG_D = 5; W_REG_D_V = 32'h11;
    I_PC = 32'h200; I_INST = 32'h00528333; I_VALID = 1;
    cycle();
    STALL = 1; W_REG_D_V = 32'hAB;
    #2;
    chk("byp_s1", 0, a_s1v[0], 32'hAB);
    chk("byp_s2", 0, a_s2v[0], 32'hAB);
    chk("nob_s1", 1, a_s1v[1], 32'h11);
    chk("nob_s2", 1, a_s2v[1], 32'h11);
    #1;
    cycle();
    W_VALID = 0;
    #2;
    chk("late_s1", 1, a_s1v[1], 32'hAB);
    chk("late_s2", 1, a_s2v[1], 32'hAB);
    #1;
    cycle();
    STALL = 0;

    // ---- x0 write is ignored and never forwarded
    I_INST = 32'h00000033; I_PC = 32'h300;
    cycle();
    W_VALID = 1; W_REG_D = 0; W_REG_D_V = 32'hFF; DBG_ADDR = 0;
    #2;
    chk("x0_fwd", 0, a_s1v[0], 32'd0);
    #1;
    cycle();
    W_VALID = 0;
    #2;
    chk("x0_dbg", 0, a_dbg[0], 32'd0);
    #1;

    // ---- stall for 3 cycles with a write-back in flight, then flush+stall
    I_PC = 32'h104; I_INST = 32'h00000013; I_VALID = 1;
    cycle();
    STALL = 1; W_VALID = 1; W_REG_D = 7; W_REG_D_V = 32'h55; DBG_ADDR = 7;
    for (int i = 0; i < 3; i++) begin
      I_PC = 32'h500 + 32'(i * 4); I_INST = 32'h00A00513;
      cycle();
      for (int k = 0; k < 2; k++) chk("stall_pc", k, a_pc[k], 32'h104);
    end
    W_VALID = 0;
    #2;
    for (int k = 0; k < 2; k++) chk("stall_dbg7", k, a_dbg[k], 32'h55);
    #1;
    FLUSH = 1; I_VALID = 1;
    cycle();
    for (int k = 0; k < 2; k++) chk("flush_valid", k, 32'(a_valid[k]), 32'd0);
    idle_inputs();
    cycle();

    // ---- randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = $urandom();
      if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 10)];
      I_INST    = ins;
      I_PC      = $urandom() & 32'hFFFF_FFFC;
      I_VALID   = ($urandom_range(0, 4) != 0);
      STALL     = ($urandom_range(0, 4) == 0);
      FLUSH     = ($urandom_range(0, 9) == 0);
      W_VALID   = ($urandom_range(0, 2) != 0);
      W_REG_D   = 5'($urandom_range(0, 31));
      W_REG_D_V = $urandom();
      DBG_ADDR  = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_rf.md
# decode_rf

Parametrised RV32I decode stage with integrated register file: the successor to the fixed 32-register decode stage. Latches the fetched instruction into the IF/ID pipeline register, extracts fields, and produces sign-extended immediates. Reads two source operands with optional write-back bypass and flags illegal encodings. Sits between fetch and execute; write-back arrives from the memory/write-back stage.

## Interface
- XLEN, 32: register and operand width (32 or 64); immediates sign-extend to XLEN.
- NREG, 32: architectural register count (16 for RV32E, 32 for RV32I); x0 is always zero.
- BYPASS, 1: 1 forwards a same-cycle write-back value to the read ports; 0 returns the pre-write value.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-low.
- STALL  in  1  holds the pipeline register.
- FLUSH  in  1  invalidates the pipeline register.
- I_PC  in  32  fetched PC.
- I_INST  in  32  fetched instruction.
- I_VALID  in  1  fetch slot valid.
- W_VALID  in  1  write-back commit strobe.
- W_REG_D  in  5  write-back destination index.
- W_REG_D_V  in  XLEN  write-back data.
- D_PC  out  32  latched PC.
- D_INST  out  32  latched instruction.
- D_VALID  out  1  latched valid.
- D_OPCODE  out  7  inst[6:0].
- D_FUNCT3  out  3  inst[14:12].
- D_FUNCT7  out  7  inst[31:25].
- D_IMM  out  XLEN  sign-extended immediate.
- D_REG_D  out  5  rd; 0 for S/B formats.
- D_REG_S1  out  5  rs1 (inst[19:15]).
- D_REG_S2  out  5  rs2 (inst[24:20]).
- D_REG_S1_V  out  XLEN  rs1 value.
- D_REG_S2_V  out  XLEN  rs2 value.
- D_ILLEGAL  out  1  valid slot holds an unsupported opcode or a register index >= NREG.
- DBG_ADDR  in  5  debug read index.
- DBG_DATA  out  XLEN  debug read value (no bypass), 0 for index 0 or >= NREG.

## Operation
- Pipeline register (pc, inst, valid): FLUSH loads 0/0/0. Otherwise, if STALL is low, it loads I_PC/I_INST/I_VALID. FLUSH takes priority over STALL.
- Field outputs are combinational from the pipeline register.
- Immediates, each sign-extended from its top bit to XLEN:
  - I (opcodes 1100111, 0000011, 0010011, 0001111, 1110011): inst[31:20].
  - S (0100011): {inst[31:25], inst[11:7]}.
  - B (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - J (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - U (0110111, 0010111): {inst[31:12], 12'b0}, sign-extended to XLEN.
  - R (0110011) and unknown opcodes: 0.
- D_ILLEGAL = D_VALID & (unknown opcode | any used index >= NREG). Used indices:
  - rd for R/I/U/J.
  - rs1 for R/I/S/B.
  - rs2 for R/S/B.
- Register file: NREG-1 physical XLEN-bit registers (x1..x(NREG-1)).
- Write: on W_VALID, write W_REG_D_V to W_REG_D. Writes to index 0 or index >= NREG are dropped.
- Writes are independent of STALL and FLUSH; the write-back stage deasserts W_VALID when it is not committing.
- Read of index 0 or index >= NREG returns 0.
- Bypass (BYPASS=1): if W_VALID and W_REG_D == rsN, rsN != 0 and rsN < NREG, then D_REG_SN_V = W_REG_D_V in the same cycle.

## Timing
- Reset (RST low, asynchronous): pipeline register and all registers clear immediately. All outputs except DBG_DATA read 0, including D_VALID, D_ILLEGAL and D_IMM. A reset mid-stall or mid-write discards the pending update.
- Latency: I_* to D_* is 1 cycle. Write-back to architectural read:
  - BYPASS=1: 0 cycles.
  - BYPASS=0: 1 cycle.
- STALL held N cycles: D_* is frozen N cycles; the I_* presented during the stall is lost (fetch holds it).
- FLUSH and I_VALID in the same cycle: D_VALID=0 next cycle.
- Simultaneous W_VALID to rs1 and rs2 of the same index: both ports bypass.
- W_REG_D = 0 with W_VALID: no state change and no bypass.

## Test plan
- Reset/load: assert RST low mid-run, then release. Present I_INST=0x00500093 (addi x1,x0,5), I_PC=0x100, I_VALID=1. Next cycle: D_VALID=1, D_PC=0x100, D_REG_D=1, D_IMM=5, D_ILLEGAL=0.
- Sign extension: I_INST=0xFFF00093 (addi x1,x0,-1) gives D_IMM=0xFFFFFFFF (XLEN=64: all ones). I_INST=0xFE000EE3 (beq, offset -4) gives D_IMM=-4.
- Write/bypass: with x5 holding 0x11, decode add x6,x5,x5 while W_VALID=1, W_REG_D=5, W_REG_D_V=0xAB.
  - BYPASS=1: both operands 0xAB in the same cycle.
  - BYPASS=0: both 0x11, then 0xAB next cycle.
- x0 and illegal: W_VALID to x0 with 0xFF leaves DBG_DATA(0)=0. With NREG=16, addi x20,x0,1 gives D_ILLEGAL=1. Opcode 0x7F gives D_ILLEGAL=1, D_IMM=0.
- Stall/flush: STALL=1 for 3 cycles freezes D_PC=0x104 while W_VALID writes x7=0x55 (DBG_DATA(7)=0x55). Raising FLUSH and STALL together gives D_VALID=0 next cycle.
